// File: rtl/codec_pkg.sv
// Shared constants for the I2S codec interface: counter geometry and the
// counter decode values that mark SCLK edges and word-load slots.
package codec_pkg;

    localparam int SMPL_W   = 16;
    localparam int CNT_W    = 10;
    localparam int MCLK_BIT = 1;
    localparam int SCLK_BIT = 4;
    localparam int SLOT_LSB = 5;   // cnt[CNT_W-1:SLOT_LSB] numbers the SCLK period in the frame

    // Phase within one SCLK period, taken on the clk edge where SCLK toggles
    localparam logic [SLOT_LSB-1:0] SCLK_RISE_PH = 5'b01111;
    localparam logic [SLOT_LSB-1:0] SCLK_FALL_PH = 5'b11111;

    // SCLK period indices (cnt[9:5]) carrying the last bit of each received word
    localparam logic [CNT_W-SLOT_LSB-1:0] LFT_LOAD_SLOT = 5'b10000;
    localparam logic [CNT_W-SLOT_LSB-1:0] RHT_LOAD_SLOT = 5'b00000;

    // Period index within a half (cnt[8:5]) whose falling edge loads the TX word
    localparam logic [CNT_W-SLOT_LSB-2:0] TX_LOAD_SLOT = 4'b0000;

endpackage

// File: rtl/codec_intf.sv
// I2S master towards an audio codec: derives LRCLK/SCLK/MCLK from one
// free-running counter, deserialises SDout and serialises the DAC samples.
module codec_intf #(
    parameter int SMPL_W = codec_pkg::SMPL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [SMPL_W-1:0] lft_in,
    input  logic signed [SMPL_W-1:0] rht_in,
    input  logic                     SDout,
    output logic signed [SMPL_W-1:0] lft_out,
    output logic signed [SMPL_W-1:0] rht_out,
    output logic                     valid,
    output logic                     LRCLK,
    output logic                     SCLK,
    output logic                     MCLK,
    output logic                     SDin,
    output logic                     RSTn
);
    import codec_pkg::*;

    logic [CNT_W-1:0]          cnt_reg;
    logic                      rstn_reg;
    logic                      valid_reg;
    // The RX register only needs SMPL_W-1 bits: the oldest bit is consumed
    // on the same edge that the newest one arrives.
    logic [SMPL_W-2:0]         rx_shreg;
    logic [SMPL_W-1:0]         tx_shreg;
    logic [SMPL_W-1:0]         lft_reg;
    logic [SMPL_W-1:0]         rht_reg;
    logic [SMPL_W-1:0]         rx_word;
    logic [CNT_W-SLOT_LSB-1:0] slot;
    logic                      sclk_rise;
    logic                      sclk_fall;
    logic                      tx_load;

    assign slot      = cnt_reg[CNT_W-1:SLOT_LSB];
    assign sclk_rise = (cnt_reg[SLOT_LSB-1:0] == SCLK_RISE_PH);
    assign sclk_fall = (cnt_reg[SLOT_LSB-1:0] == SCLK_FALL_PH);
    assign tx_load   = sclk_fall && (slot[CNT_W-SLOT_LSB-2:0] == TX_LOAD_SLOT);
    assign rx_word   = {rx_shreg, SDout};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            rstn_reg  <= 1'b0;
            valid_reg <= 1'b0;
            rx_shreg  <= '0;
            tx_shreg  <= '0;
            lft_reg   <= '0;
            rht_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);

            // Codec leaves reset once a full frame of clocks has been issued
            if (cnt_reg == {CNT_W{1'b1}}) begin
                rstn_reg <= 1'b1;
            end

            if (sclk_rise) begin
                rx_shreg <= rx_word[SMPL_W-2:0];
                if (slot == LFT_LOAD_SLOT) begin
                    lft_reg <= rx_word;
                end
                if (slot == RHT_LOAD_SLOT) begin
                    rht_reg <= rx_word;
                end
            end

            // A pair is only trustworthy once the codec ran out of reset for it
            valid_reg <= sclk_rise && (slot == RHT_LOAD_SLOT) && rstn_reg;

            if (tx_load) begin
                tx_shreg <= cnt_reg[CNT_W-1] ? rht_in : lft_in;
            end else if (sclk_fall) begin
                tx_shreg <= {tx_shreg[SMPL_W-2:0], 1'b0};
            end
        end
    end

    assign LRCLK   = cnt_reg[CNT_W-1];
    assign SCLK    = cnt_reg[SCLK_BIT];
    assign MCLK    = cnt_reg[MCLK_BIT];
    assign RSTn    = rstn_reg;
    assign SDin    = tx_shreg[SMPL_W-1];
    assign valid   = valid_reg;
    assign lft_out = lft_reg;
    assign rht_out = rht_reg;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: a bit-level I2S codec model plus a
// frame-timing model derived from the elapsed clock count since reset.
module tb_codec_intf;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] lft_in;
    logic signed [15:0] rht_in;
    logic               SDout;
    logic signed [15:0] lft_out;
    logic signed [15:0] rht_out;
    logic               valid;
    logic               LRCLK;
    logic               SCLK;
    logic               MCLK;
    logic               SDin;
    logic               RSTn;

    codec_intf #(.SMPL_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .SDout   (SDout),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .valid   (valid),
        .LRCLK   (LRCLK),
        .SCLK    (SCLK),
        .MCLK    (MCLK),
        .SDin    (SDin),
        .RSTn    (RSTn)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          t = 0;          // clk edges since reset release
    int          valid_cnt = 0;
    int          mode = 1;       // 0 random, 1 codec words, 2 loopback
    logic [15:0] codec_l = 16'h1234;
    logic [15:0] codec_r = 16'hA5C3;
    bit          rx_q[$];        // last 16 SDout bits seen on SCLK rises
    bit          tx_q[$];        // last 16 SDin bits seen on SCLK rises
    logic [15:0] exp_lft, exp_rht, exp_tx_l, exp_tx_r;
    bit          rht_loaded;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [15:0] pack16(input bit q[$]);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) w = {w[14:0], q[i]};
        return w;
    endfunction

    // I2S codec: period 0 of each half still carries the previous word's LSB
    function automatic bit codec_bit(input int c);
        int p   = c / 32;
        int idx = p % 16;
        bit rgt = (p >= 16);
        if (idx == 0) return rgt ? codec_l[0] : codec_r[0];
        return rgt ? codec_r[16 - idx] : codec_l[16 - idx];
    endfunction

    task automatic drive_inputs();
        case (mode)
            0: begin
                SDout  = 1'($urandom);
                lft_in = 16'($urandom);
                rht_in = 16'($urandom);
            end
            1: SDout = codec_bit(t % 1024);
            default: SDout = SDin;
        endcase
    endtask

    task automatic tick();
        int c;
        bit rx_bit, tx_bit;
        c = t % 1024;
        rx_bit = SDout;
        tx_bit = SDin;
        if (c == 'h01F) exp_tx_l = lft_in;
        if (c == 'h21F) begin
            exp_tx_r   = rht_in;
            rht_loaded = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
        if (c % 32 == 15) begin
            rx_q.push_back(rx_bit);
            void'(rx_q.pop_front());
            tx_q.push_back(tx_bit);
            void'(tx_q.pop_front());
        end
        if (c == 'h20F) begin
            exp_lft = pack16(rx_q);
            check("tx_left_word", pack16(tx_q), exp_tx_l);
        end
        if (c == 'h00F) begin
            exp_rht = pack16(rx_q);
            if (rht_loaded) check("tx_right_word", pack16(tx_q), exp_tx_r);
        end
        check("LRCLK", 16'((t / 512) % 2), 16'(LRCLK));
        check("SCLK", 16'(SCLK), 16'((t / 16) % 2));
        check("MCLK", 16'(MCLK), 16'((t / 2) % 2));
        check("RSTn", 16'(RSTn), 16'(t >= 1024));
        check("valid", 16'(valid), 16'((t >= 1040) && (t % 1024 == 16)));
        check("lft_out", lft_out, exp_lft);
        check("rht_out", rht_out, exp_rht);
        if (valid) valid_cnt++;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_lft_out", lft_out, 16'h0);
        check("rst_rht_out", rht_out, 16'h0);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_LRCLK", 16'(LRCLK), 16'h0);
        check("rst_SCLK", 16'(SCLK), 16'h0);
        check("rst_MCLK", 16'(MCLK), 16'h0);
        check("rst_SDin", 16'(SDin), 16'h0);
        check("rst_RSTn", 16'(RSTn), 16'h0);
        repeat (3) @(posedge clk);
        #1;
        t = 0;
        valid_cnt = 0;
        rx_q.delete();
        tx_q.delete();
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(1'b0);
            tx_q.push_back(1'b0);
        end
        exp_lft = '0;
        exp_rht = '0;
        rht_loaded = 1'b0;
        drive_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        lft_in = 16'sh8001;
        rht_in = 16'sh7FFE;
        SDout  = 1'b0;
        #2;

        // Power-on reset, codec model sending fixed words, fixed DAC samples
        mode = 1;
        reset_dut();
        run(3072);
        check("codec_lft_out", lft_out, 16'h1234);
        check("codec_rht_out", rht_out, 16'hA5C3);
        check("valid_per_frame", 16'(valid_cnt), 16'd2);

        // Random SDout bits and DAC samples changing every clk
        mode = 0;
        run(3072);

        // Loopback SDout = SDin
        mode   = 2;
        lft_in = 16'sh0F0F;
        rht_in = -16'sh0F10;   // 0xF0F0
        run(2048);
        check("loop_lft_out", lft_out, 16'h0F0F);
        check("loop_rht_out", rht_out, 16'hF0F0);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 1024 && (t % 1024) != 'h180; i++) tick();
        check("reached_0x180", 16'(t % 1024), 16'h180);
        reset_dut();
        run(1039);
        check("no_early_valid", 16'(valid_cnt), 16'd0);
        run(1);
        check("first_valid_after_reset", 16'(valid_cnt), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codec_intf.md
CODEC_INTF -- requirements
Module: codec_intf

Interface
REQ-001 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port lft_in, input, 16 signed, left sample to transmit to the codec (equalizer output).
REQ-004 SHALL have port rht_in, input, 16 signed, right sample to transmit to the codec.
REQ-005 SHALL have port SDout, input, 1, serial ADC data from the codec.
REQ-006 SHALL have port lft_out, output, 16 signed, registered received left sample.
REQ-007 SHALL have port rht_out, output, 16 signed, registered received right sample.
REQ-008 SHALL have port valid, output, 1, one-clk pulse marking a new lft_out/rht_out pair.
REQ-009 SHALL have port LRCLK, output, 1, frame clock (0 = left half, 1 = right half).
REQ-010 SHALL have port SCLK, output, 1, serial bit clock.
REQ-011 SHALL have port MCLK, output, 1, codec master clock.
REQ-012 SHALL have port SDin, output, 1, serial DAC data to the codec.
REQ-013 SHALL have port RSTn, output, 1, codec reset, active low.
REQ-014 SHALL have parameter SMPL_W, default 16, sample width.

Function
REQ-015 SHALL have a free-running 10-bit counter cnt, incremented every clk, wrapping 0x3FF->0x000.
REQ-016 SHALL drive LRCLK=cnt[9], SCLK=cnt[4], MCLK=cnt[1] directly from flops (glitch-free); frame = 1024 clk, 16 SCLK periods per half.
REQ-017 SHALL define sclk_rise as cnt[4:0]==5'b01111 and sclk_fall as cnt[4:0]==5'b11111 (events on the edge where SCLK changes).
REQ-018 SHALL hold RSTn low from reset until the first cnt wrap 0x3FF->0x000, then hold it high until the next reset.
REQ-019 Receive: on every sclk_rise, SHALL shift SDout into a 16-bit shift register, MSB first (I2S, one-SCLK delay after the LRCLK edge).
REQ-020 SHALL load lft_out <= {shreg[14:0],SDout} on the sclk_rise with cnt[9:5]==5'b10000.
REQ-021 SHALL load rht_out <= {shreg[14:0],SDout} on the sclk_rise with cnt[9:5]==5'b00000.
REQ-022 SHALL assert valid for exactly one clk, the cycle after each rht_out load, only when RSTn was high for the whole frame; the first valid follows the second rht_out load after reset.
REQ-023 lft_out/rht_out SHALL hold their values between loads.
REQ-024 Transmit: on the sclk_fall with cnt[8:5]==4'b0000, SHALL load the TX shift register from lft_in if cnt[9]==0, else from rht_in.
REQ-025 On every other sclk_fall, SHALL shift the TX register left by one; SDin = TX register MSB (registered).
REQ-026 The LSB of each word SHALL be driven during SCLK period 0 of the following half, consistent with the I2S one-bit delay.
REQ-027 lft_in/rht_in SHALL be sampled only at the REQ-024 load edges; changes between loads have no effect.
REQ-028 Receive and transmit paths SHALL operate concurrently and independently of valid.

Reset
REQ-029 On rst_n low, SHALL asynchronously clear cnt, LRCLK, SCLK, MCLK, RSTn, SDin, valid, lft_out, rht_out and both shift registers to 0.
REQ-030 Reset mid-frame SHALL abort the frame; no valid pulse until REQ-022 is satisfied again.

Structure
REQ-031 The package codec_pkg SHALL hold SMPL_W, CNT_W=10, and the decode constants for sclk_rise, sclk_fall and the load indices.
REQ-032 The block SHALL be a single module with no sub-modules; clock generation, RX and TX share cnt.

Verification
REQ-033 Reset released: RSTn=0 until cnt wraps at clk 1024, then 1; MCLK period = 4 clk, SCLK period = 32 clk, LRCLK period = 1024 clk.
REQ-034 Codec model sends left=0x1234, right=0xA5C3 with I2S timing: after the next rht_out load, lft_out=0x1234 and rht_out=0xA5C3, and valid pulses exactly once per frame.
REQ-035 lft_in=0x8001, rht_in=0x7FFE held: the SDin bits captured on SCLK rises 2..17 of each half = 0x8001 (left) and 0x7FFE (right).
REQ-036 Loopback SDout=SDin with lft_in=0x0F0F, rht_in=0xF0F0: lft_out=0x0F0F and rht_out=0xF0F0 within two frames.
REQ-037 rst_n pulsed low at cnt=0x180: all outputs are 0 immediately (asynchronously); no valid pulse before one full frame with RSTn high.
